// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the control FSM / address stage and the PC sequencer.
// master drives state, flags and target; slave (the sequencer) returns PC and status.
interface pc_sequencer_if #(
   parameter int unsigned addr = 20,
   parameter int unsigned st   = 3
) ();

   logic [st-1:0]   State;
   logic            flagBRANCH;
   logic            flagJUMP;
   logic            flagJR;
   logic            flagIN;
   logic            flagHALT;
   logic            enter;
   logic [addr-1:0] newAddress;

   logic [addr-1:0] PC;
   logic [addr-1:0] addressJAL;
   logic            stall;
   logic            inCapture;
   logic            halted;
   logic            pcUpdate;

   modport master (
      output State, flagBRANCH, flagJUMP, flagJR, flagIN, flagHALT, enter, newAddress,
      input  PC, addressJAL, stall, inCapture, halted, pcUpdate
   );

   modport slave (
      input  State, flagBRANCH, flagJUMP, flagJR, flagIN, flagHALT, enter, newAddress,
      output PC, addressJAL, stall, inCapture, halted, pcUpdate
   );

endinterface

// File: rtl/pc_sequencer.sv
// Program counter and instruction sequencing: PC advance/jump, IN wait-for-enter stall
// and the absorbing HALT state. All outputs are registered.
module pc_sequencer #(
   parameter int unsigned   addr      = 20,
   parameter int unsigned   st        = 3,
   parameter logic [st-1:0] UPDATE_ST = 3'd4
) (
   input logic          clock,
   input logic          reset,
   pc_sequencer_if.slave bus
);

   localparam logic [addr-1:0] AddrOne = {{(addr-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StRun, StWaitIn, StWaitRel, StHalt} mode_e;

   mode_e           mode_q;
   logic [addr-1:0] pc_q;
   logic [addr-1:0] jal_q;
   logic            stall_q;
   logic            in_capture_q;
   logic            halted_q;
   logic            pc_update_q;

   logic            jump_any;
   logic [addr-1:0] target_inc;
   logic [addr-1:0] jal_inc;

   assign jump_any   = bus.flagJR | bus.flagJUMP | bus.flagBRANCH;
   assign target_inc = bus.newAddress + AddrOne;
   // jal_q already holds PC+1, so sequential advance is PC <= jal_q, jal <= jal_q+1.
   assign jal_inc    = jal_q + AddrOne;

   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q       <= StRun;
         pc_q         <= '0;
         jal_q        <= AddrOne;
         stall_q      <= 1'b0;
         in_capture_q <= 1'b0;
         halted_q     <= 1'b0;
         pc_update_q  <= 1'b0;
      end else begin
         in_capture_q <= 1'b0;
         pc_update_q  <= 1'b0;
         unique case (mode_q)
            StRun: begin
               if (bus.State == UPDATE_ST) begin
                  if (bus.flagHALT) begin
                     mode_q   <= StHalt;
                     stall_q  <= 1'b1;
                     halted_q <= 1'b1;
                  end else if (bus.flagIN) begin
                     mode_q  <= StWaitIn;
                     stall_q <= 1'b1;
                  end else if (jump_any) begin
                     pc_q        <= bus.newAddress;
                     jal_q       <= target_inc;
                     pc_update_q <= 1'b1;
                  end else begin
                     pc_q        <= jal_q;
                     jal_q       <= jal_inc;
                     pc_update_q <= 1'b1;
                  end
               end
            end
            StWaitIn: begin
               if (bus.enter) begin
                  mode_q       <= StWaitRel;
                  in_capture_q <= 1'b1;
               end
            end
            StWaitRel: begin
               if (!bus.enter) begin
                  mode_q      <= StRun;
                  stall_q     <= 1'b0;
                  pc_q        <= jal_q;
                  jal_q       <= jal_inc;
                  pc_update_q <= 1'b1;
               end
            end
            StHalt: begin
               mode_q <= StHalt;
            end
            default: begin
               mode_q <= StRun;
            end
         endcase
      end
   end

   assign bus.PC         = pc_q;
   assign bus.addressJAL = jal_q;
   assign bus.stall      = stall_q;
   assign bus.inCapture  = in_capture_q;
   assign bus.halted     = halted_q;
   assign bus.pcUpdate   = pc_update_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and instruction-sequencing stage directly upstream of the address/RD-mux stage. It consumes that stage's flagBRANCH and its resolved 20-bit target address, and produces the instruction-memory address PC. It also produces addressJAL, the return address fed back downstream for JAL writeback. It owns the halt state and the wait-for-user-input stall used by IN instructions.

Parameters:
addr, 20, program-counter / instruction-address width
st, 3, width of the control-FSM State bus
UPDATE_ST, 3'd4, State code in which PC advances (last state of each instruction)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
State  input  st  current control-FSM state
flagBRANCH  input  1  branch taken, from the address/RD-mux stage
flagJUMP  input  1  unconditional jump (J/JAL)
flagJR  input  1  jump-register instruction
flagIN  input  1  current instruction is IN (waits for user entry)
flagHALT  input  1  current instruction is HALT
enter  input  1  user confirm button, level, already synchronized
newAddress  input  addr  resolved target; register value for JR, immediate for J/JAL/branch
PC  output  addr  current instruction address
addressJAL  output  addr  PC+1 of current instruction, JAL return address
stall  output  1  holds control FSM in its present state
inCapture  output  1  one-cycle pulse; the register file latches IN
halted  output  1  processor stopped
pcUpdate  output  1  one-cycle pulse on each PC load

Behaviour:
- Internal FSM: RUN, WAIT_IN, WAIT_REL, HALT. Encoding is free.
- Reset, synchronous and dominant over everything else:
  - FSM = RUN
  - PC = 0, addressJAL = 1
  - stall = 0, inCapture = 0, halted = 0, pcUpdate = 0
  - Reset asserted in any mode, including mid-WAIT_IN or HALT, returns to these values on the next edge.
- RUN, when State == UPDATE_ST, one decision per cycle. Priority:
  1. flagHALT: go to HALT. PC holds.
  2. flagIN: go to WAIT_IN. PC holds.
  3. flagJR or flagJUMP or flagBRANCH: PC <= newAddress.
  4. Otherwise: PC <= PC+1.
- In cases 3 and 4, pcUpdate = 1 for that cycle, registered with the PC load.
- RUN with State != UPDATE_ST: PC and addressJAL hold, pcUpdate = 0.
- Multiple jump flags asserted together all select newAddress. This is not an error.
- Arithmetic: PC+1 is modulo 2^addr. 20'hFFFFF increments to 0.
- addressJAL is registered and always equals PC+1 (mod 2^addr). It updates on the same edge PC loads, so it is valid throughout the following instruction.
- stall is a registered output:
  - 1 in WAIT_IN, WAIT_REL and HALT; 0 in RUN.
  - Asserts on the edge that enters WAIT_IN or HALT.
- WAIT_IN: stays until enter == 1, then goes to WAIT_REL. inCapture = 1 for exactly that one cycle (registered, coincident with entering WAIT_REL).
- WAIT_REL: stays until enter == 0, then goes to RUN, with PC <= PC+1, pcUpdate = 1 and stall = 0 on that edge.
  - Holding enter high produces no further inCapture pulses.
  - If enter is already high when WAIT_IN is entered, capture happens on the next cycle; a fresh press is not required.
- HALT: absorbing. PC, addressJAL and halted = 1 hold; all flags and enter are ignored. Only reset exits.
- flagIN and flagHALT together in UPDATE_ST: HALT wins.
- Inputs are sampled only at UPDATE_ST in RUN. Flags in other states are ignored.
- Latency: PC is visible one cycle after the UPDATE_ST cycle.

Test Plan:
- Reset, then 5 UPDATE_ST passes with no flags -> PC 0,1,2,3,4,5; addressJAL 1..6; five pcUpdate pulses.
- PC = 20'h00010, flagBRANCH = 1, newAddress = 20'h00100 at UPDATE_ST -> PC = 20'h00100, addressJAL = 20'h00101. Same stimulus with State = 3'd2 -> PC unchanged.
- PC = 20'hFFFFF, no flags at UPDATE_ST -> PC = 0, addressJAL = 1. With flagJR = 1, newAddress = 20'h0ABCD -> PC = 20'h0ABCD.
- flagIN at UPDATE_ST, PC = 7 -> stall = 1, PC stays 7. Enter high for 4 cycles -> single inCapture pulse. Enter low -> PC = 8, stall = 0.
- flagHALT and flagIN together at PC = 3 -> halted = 1, stall = 1, PC stays 3 for 50 cycles despite flags and enter toggling. Reset -> PC = 0, halted = 0.
- Reset asserted while in WAIT_REL with enter high -> next edge: RUN, stall = 0, PC = 0. No inCapture pulse after reset.
